// File: rtl/command_tx_pkg.sv
// Shared types and sizing for the command transmitter.
// COMMAND_TX_CHECKSUM_EN adds a fourth, XOR checksum byte to every frame.
package command_tx_pkg;

    localparam int CMD_ADDR_W = 8;
    localparam int CMD_DATA_W = 16;
    localparam int IDX_W      = 2;

`ifdef COMMAND_TX_CHECKSUM_EN
    localparam int FRAME_BYTES = 4;
`else
    localparam int FRAME_BYTES = 3;
`endif

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_IDLE  = 4'd1,
        ST_START = 4'd2,
        ST_DATA  = 4'd3,
        ST_STOP  = 4'd4
    } state_t;

    typedef enum logic [1:0] {
        SEQ_RESET = 2'd0,
        SEQ_IDLE  = 2'd1,
        SEQ_FRAME = 2'd2
    } seq_t;

`ifdef COMMAND_TX_CHECKSUM_EN
    function automatic logic [7:0] frame_checksum(input logic [CMD_ADDR_W-1:0] addr,
                                                  input logic [CMD_DATA_W-1:0] data);
        return addr ^ data[7:0] ^ data[15:8];
    endfunction
`endif

endpackage

// File: rtl/command_tx_if.sv
// Command handshake between a command source and command_tx.
interface command_tx_if;
    import command_tx_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [CMD_ADDR_W-1:0] cmd_addr;
    logic [CMD_DATA_W-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_addr, output cmd_data, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_addr, input  cmd_data, output cmd_ready);

endinterface

// File: rtl/command_tx_tx.sv
// Single-byte 8N1 serialiser with a registered line output.
//   state    | meaning
//   ST_IDLE  | line high, waiting for tx_start
//   ST_START | start bit (0) for BAUD_DIV cycles
//   ST_DATA  | 8 data bits, LSB first, BAUD_DIV cycles each
//   ST_STOP  | stop bit (1); tx_start on its last cycle chains the next byte
module command_tx_tx
    import command_tx_pkg::*;
#(
    parameter int BAUD_DIV = 128
) (
    input  logic       i_clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       uart_tx
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d, baud_nxt;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             baud_end;

    assign baud_end = (baud_q == BAUD_LAST);
    assign baud_nxt = baud_end ? '0 : baud_q + 1'b1;
    assign uart_tx  = tx_q;
    // Busy drops during the final stop cycle so the next byte can start without a gap.
    assign tx_busy  = (state_q != ST_IDLE) && !((state_q == ST_STOP) && baud_end);

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d = ST_START;
                    baud_d  = '0;
                    shift_d = tx_data;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                baud_d = baud_nxt;
                if (baud_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                baud_d = baud_nxt;
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                baud_d = baud_nxt;
                if (baud_end) begin
                    if (tx_start) begin
                        state_d = ST_START;
                        shift_d = tx_data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/command_tx.sv
// Command transmitter: accepts {addr, data} and sends addr, data[7:0], data[15:8] as 8N1 bytes.
// With COMMAND_TX_CHECKSUM_EN a fourth byte addr ^ data[7:0] ^ data[15:8] follows.
module command_tx
    import command_tx_pkg::*;
#(
    parameter int BAUD_DIV = 128
) (
    input  logic         i_clk,
    input  logic         rst,
    command_tx_if.slave  cmd,
    output logic         uart_tx,
    output logic         busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    seq_t                          seq_q, seq_d;
    logic [IDX_W-1:0]              idx_q, idx_d, idx_nxt;
    logic [FRAME_BYTES-1:1][7:0]   hold_q;
    logic                          accept;
    logic                          tx_start;
    logic                          tx_busy;
    logic [7:0]                    tx_data;

    assign cmd.cmd_ready = (seq_q == SEQ_IDLE);
    assign busy          = !cmd.cmd_ready;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign idx_nxt       = idx_q + 1'b1;

    // Byte 0 goes straight from cmd_addr to the serialiser, so only later bytes are held.
    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            seq_q  <= SEQ_RESET;
            idx_q  <= '0;
            hold_q <= '0;
        end else begin
            seq_q <= seq_d;
            idx_q <= idx_d;
            if (accept) begin
                hold_q[1] <= cmd.cmd_data[7:0];
                hold_q[2] <= cmd.cmd_data[15:8];
`ifdef COMMAND_TX_CHECKSUM_EN
                hold_q[3] <= frame_checksum(cmd.cmd_addr, cmd.cmd_data);
`endif
            end
        end
    end

    always_comb begin
        seq_d    = seq_q;
        idx_d    = idx_q;
        tx_start = 1'b0;
        tx_data  = cmd.cmd_addr;
        case (seq_q)
            SEQ_RESET: seq_d = SEQ_IDLE;
            SEQ_IDLE: begin
                if (accept) begin
                    seq_d    = SEQ_FRAME;
                    idx_d    = '0;
                    tx_start = 1'b1;
                end
            end
            SEQ_FRAME: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        seq_d = SEQ_IDLE;
                    end else begin
                        idx_d    = idx_nxt;
                        tx_start = 1'b1;
                        tx_data  = hold_q[idx_nxt];
                    end
                end
            end
            default: seq_d = SEQ_IDLE;
        endcase
    end

    command_tx_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .i_clk    (i_clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .uart_tx  (uart_tx)
    );

endmodule
